lmul_unit: RTL and testbench

//   Iterative 32x32->64 long-multiply responder for the multicycle core. When decode

---
 rtl/lmul_unit_if.sv | 28 ++
 rtl/lmul_unit.sv | 141 ++++++++++++++
 tb/tb_lmul_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lmul_unit_if.sv
// Request/response bundle between the multicycle controller and the long-multiply unit.
// The controller side uses the master modport; the multiplier uses the slave modport.
interface lmul_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic                 accumulate;
  logic                 flush;
  logic [WIDTH-1:0]     SrcA;
  logic [WIDTH-1:0]     SrcB;
  logic [2*WIDTH-1:0]   AccIn;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     ResultLo;
  logic [WIDTH-1:0]     ResultHi;
  logic [1:0]           MulFlags;

  modport master (
    output start, is_signed, accumulate, flush, SrcA, SrcB, AccIn,
    input  busy, done, ResultLo, ResultHi, MulFlags
  );

  modport slave (
    input  start, is_signed, accumulate, flush, SrcA, SrcB, AccIn,
    output busy, done, ResultLo, ResultHi, MulFlags
  );
endinterface

// File: rtl/lmul_unit.sv
// Iterative radix-2 shift-add 32x32->64 long multiplier (UMULL/SMULL/UMLAL/SMLAL)
// with sign fix-up and 64-bit accumulate in a final FIX cycle.
module lmul_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  lmul_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
  localparam logic [2*WIDTH-1:0] ONE_D    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ZERO_D   = {(2*WIDTH){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        count_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic                 neg_r;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     res_lo_r;
  logic [WIDTH-1:0]     res_hi_r;
  logic [1:0]           flags_r;

  logic [2*WIDTH-1:0]   step_sum_s;
  logic [2*WIDTH-1:0]   signed_prod_s;
  logic [2*WIDTH-1:0]   fix_sum_s;

  // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    if (sgn && v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Partial-product step and final sign/accumulate fix-up datapath.
  always_comb begin
    step_sum_s    = prod_r;
    signed_prod_s = prod_r;
    if (mplier_r[0]) begin
      step_sum_s = prod_r + mcand_r;
    end else begin
      step_sum_s = prod_r;
    end
    if (neg_r) begin
      signed_prod_s = ~prod_r + ONE_D;
    end else begin
      signed_prod_s = prod_r;
    end
    fix_sum_s = signed_prod_s + acc_r;
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      count_r  <= CNT_ZERO;
      mcand_r  <= ZERO_D;
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= ZERO_D;
      acc_r    <= ZERO_D;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      res_lo_r <= {WIDTH{1'b0}};
      res_hi_r <= {WIDTH{1'b0}};
      flags_r  <= 2'b00;
    end else begin
      done_r <= 1'b0;
      if (bus.flush) begin
        // Abort wins over start; results from the last completed op stay visible.
        state_r <= IDLE;
        busy_r  <= 1'b0;
        count_r <= CNT_ZERO;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start) begin
              mcand_r  <= {{WIDTH{1'b0}}, mag(bus.SrcA, bus.is_signed)};
              mplier_r <= mag(bus.SrcB, bus.is_signed);
              prod_r   <= ZERO_D;
              neg_r    <= bus.is_signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
              acc_r    <= bus.accumulate ? bus.AccIn : ZERO_D;
              count_r  <= CNT_ZERO;
              busy_r   <= 1'b1;
              state_r  <= CALC;
            end else begin
              state_r <= IDLE;
            end
          end
          CALC: begin
            prod_r   <= step_sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + CNT_ONE;
            if (count_r == CNT_LAST) begin
              state_r <= FIX;
            end else begin
              state_r <= CALC;
            end
          end
          FIX: begin
            res_lo_r <= fix_sum_s[WIDTH-1:0];
            res_hi_r <= fix_sum_s[2*WIDTH-1:WIDTH];
            flags_r  <= {fix_sum_s[2*WIDTH-1], (fix_sum_s == ZERO_D)};
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ResultLo = res_lo_r;
  assign bus.ResultHi = res_hi_r;
  assign bus.MulFlags = flags_r;

endmodule

// File: tb/tb_lmul_unit.sv
// Directed self-checking bench for lmul_unit: latency, signed/unsigned/accumulate results,
// start-while-busy, back-to-back, async reset and flush.
module tb_lmul_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [63:0] res;

  lmul_unit_if #(.WIDTH(32)) bus ();

  lmul_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign res = {bus.ResultHi, bus.ResultLo};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                          input logic sgn, input logic accu);
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.AccIn      = acc;
    bus.is_signed  = sgn;
    bus.accumulate = accu;
    bus.start      = 1'b1;
    cyc();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++;
    if ({bus.busy, bus.done, res, bus.MulFlags} !== 68'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h flags=%b want all zero",
               bus.busy, bus.done, res, bus.MulFlags);
    end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_unsigned_max();
    int n;
    do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, 1'b0);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
    wait_done(n);
    total++;
    if (n !== 33) begin bad++; $display("FAIL latency_max: got %0d want 33", n); end
    total++;
    if (res !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL umull_max: got %h want fffffffe00000001", res); end
    total++;
    if (bus.MulFlags !== 2'b10) begin bad++; $display("FAIL umull_max_flags: got %b want 10", bus.MulFlags); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_in_done: got %b want 0", bus.busy); end
    cyc();
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
  endtask

  task automatic test_signed();
    int n;
    do_start(32'hFFFFFFFE, 32'd3, 64'd0, 1'b1, 1'b0);
    wait_done(n);
    total++;
    if (res !== 64'hFFFFFFFF_FFFFFFFA || bus.MulFlags !== 2'b10) begin
      bad++; $display("FAIL smull_neg: got %h/%b want fffffffffffffffa/10", res, bus.MulFlags);
    end
    do_start(32'hFFFFFFFE, 32'd3, 64'd0, 1'b0, 1'b0);
    wait_done(n);
    total++;
    if (res !== 64'h00000002_FFFFFFFA || bus.MulFlags !== 2'b00) begin
      bad++; $display("FAIL umull_same: got %h/%b want 00000002fffffffa/00", res, bus.MulFlags);
    end
  endtask

  task automatic test_accumulate();
    int n;
    do_start(32'd2, 32'd3, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1);
    wait_done(n);
    total++;
    if (res !== 64'h00000000_00000005 || bus.MulFlags !== 2'b00) begin
      bad++; $display("FAIL umlal_wrap: got %h/%b want 0000000000000005/00", res, bus.MulFlags);
    end
    do_start(32'd0, 32'd5, 64'd0, 1'b1, 1'b1);
    wait_done(n);
    total++;
    if (res !== 64'd0 || bus.MulFlags !== 2'b01) begin
      bad++; $display("FAIL smlal_zero: got %h/%b want 0/01", res, bus.MulFlags);
    end
    do_start(32'hFFFFFFFE, 32'd3, 64'h00000000_0000000A, 1'b1, 1'b1);
    wait_done(n);
    total++;
    if (res !== 64'd4) begin bad++; $display("FAIL smlal_sum: got %h want 4", res); end
    do_start(32'd4, 32'd5, 64'h00000000_00000064, 1'b0, 1'b0);
    wait_done(n);
    total++;
    if (res !== 64'd20) begin bad++; $display("FAIL acc_ignored: got %h want 14", res); end
  endtask

  task automatic test_start_while_busy();
    int n;
    int extra;
    do_start(32'd7, 32'd9, 64'd0, 1'b0, 1'b0);
    repeat (9) cyc();
    bus.SrcA  = 32'd100;
    bus.SrcB  = 32'd100;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_done(n);
    total++;
    if (n + 10 !== 33 || res !== 64'd63) begin
      bad++; $display("FAIL busy_start_ignored: got lat=%0d res=%h want 33/3f", n + 10, res);
    end
    extra = 0;
    repeat (40) begin
      cyc();
      if (bus.done === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL single_done: got %0d extra dones want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(32'd5, 32'd6, 64'd0, 1'b0, 1'b0);
    wait_done(n);
    total++;
    if (res !== 64'd30) begin bad++; $display("FAIL b2b_first: got %h want 1e", res); end
    do_start(32'h10, 32'h20, 64'd0, 1'b0, 1'b0);
    wait_done(n);
    total++;
    if (n !== 33 || res !== 64'h200) begin
      bad++; $display("FAIL b2b_second: got lat=%0d res=%h want 33/200", n, res);
    end
  endtask

  task automatic test_reset_and_flush();
    int n;
    int seen;
    do_start(32'h1111, 32'h2222, 64'd0, 1'b0, 1'b0);
    repeat (14) cyc();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, res, bus.MulFlags} !== 68'd0) begin
      bad++; $display("FAIL async_reset: got busy=%b done=%b res=%h flags=%b want all zero",
                      bus.busy, bus.done, res, bus.MulFlags);
    end
    cyc();
    reset = 1'b1;
    cyc();
    do_start(32'h1234, 32'h10, 64'd0, 1'b0, 1'b0);
    wait_done(n);
    total++;
    if (n !== 33 || res !== 64'h12340) begin
      bad++; $display("FAIL after_reset: got lat=%0d res=%h want 33/12340", n, res);
    end
    do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, 1'b0);
    repeat (19) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    seen = 0;
    repeat (50) begin
      cyc();
      if (bus.done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0 || res !== 64'h12340 || bus.MulFlags !== 2'b00) begin
      bad++; $display("FAIL flush_hold: got dones=%0d res=%h flags=%b want 0/12340/00", seen, res, bus.MulFlags);
    end
    bus.SrcA  = 32'd3;
    bus.SrcB  = 32'd3;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_over_start: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_most_negative();
    int n;
    do_start(32'h80000000, 32'h80000000, 64'd0, 1'b1, 1'b0);
    wait_done(n);
    total++;
    if (res !== 64'h40000000_00000000 || bus.MulFlags !== 2'b00) begin
      bad++; $display("FAIL smull_minmin: got %h/%b want 4000000000000000/00", res, bus.MulFlags);
    end
    do_start(32'h80000000, 32'd1, 64'd0, 1'b1, 1'b0);
    wait_done(n);
    total++;
    if (res !== 64'hFFFFFFFF_80000000 || bus.MulFlags !== 2'b10) begin
      bad++; $display("FAIL smull_min1: got %h/%b want ffffffff80000000/10", res, bus.MulFlags);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    bus.start      = 1'b0;
    bus.is_signed  = 1'b0;
    bus.accumulate = 1'b0;
    bus.flush      = 1'b0;
    bus.SrcA       = 32'd0;
    bus.SrcB       = 32'd0;
    bus.AccIn      = 64'd0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_accumulate();
    test_start_while_busy();
    test_back_to_back();
    test_reset_and_flush();
    test_most_negative();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
